serial_deser: RTL and testbench

Serial-to-parallel frame receiver that consumes the registered 1-bit stream produced by the single-bit D flip-flop stage (its `q` drives `din` here). It hunts for a start bit, shifts in a `WIDTH`-bit payload LSB-first, checks the stop bit (and optionally parity), and presents the word on a one-deep valid/ready output buffer. Downstream logic pulls words from that buffer.

---
 rtl/serial_deser_pkg.sv | 25 ++
 rtl/serial_deser_obuf.sv | 64 ++++++
 rtl/serial_deser.sv | 149 ++++++++++++++
 tb/tb_serial_deser.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_deser_pkg.sv
// serial_deser_pkg
// Shared types and line levels for the serial frame receiver.
//   sd_state_t   : receiver FSM states (IDLE, DATA, PAR, STOP)
//   SD_*_LEVEL   : serial line levels for idle, start and stop bits
//   sd_is_start  : true when a sampled bit marks the start of a frame
package serial_deser_pkg;

  typedef enum logic [1:0] {
    SD_IDLE = 2'd0,
    SD_DATA = 2'd1,
    SD_PAR  = 2'd2,
    SD_STOP = 2'd3
  } sd_state_t;

  localparam logic SD_IDLE_LEVEL  = 1'b0;
  localparam logic SD_START_LEVEL = 1'b1;
  localparam logic SD_STOP_LEVEL  = 1'b0;

  // A start bit must differ from the idle level, otherwise an idle line
  // would be indistinguishable from a stream of frame starts.
  function automatic logic sd_is_start(input logic b);
    return (b == SD_START_LEVEL) && (SD_START_LEVEL != SD_IDLE_LEVEL);
  endfunction

endpackage

// File: rtl/serial_deser_obuf.sv
// serial_deser_obuf
// One-deep valid/ready holding register for received words.
//   clk, rst      : clock, asynchronous active-low reset
//   load          : a good frame has completed this edge
//   load_data     : payload of that frame
//   ready         : consumer accepts data_out when valid is high
//   data_out      : held word, stable while valid is high
//   valid         : buffer holds an unconsumed word
//   overrun       : one-cycle pulse when a good frame is dropped
module serial_deser_obuf
  #(parameter int WIDTH = 8)
  (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             overrun
  );

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             accept;

  assign accept = valid_q && ready;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (load && (!valid_q || ready)) begin
      // Empty, or draining on this same edge: the new word takes the slot.
      data_d  = load_data;
      valid_d = 1'b1;
    end else begin
      if (load) begin
        overrun_d = 1'b1;
      end
      if (accept) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_out = data_q;
  assign valid    = valid_q;
  assign overrun  = overrun_q;

endmodule

// File: rtl/serial_deser.sv
// serial_deser
// Serial-to-parallel frame receiver: start bit (1), WIDTH payload bits
// LSB-first, optional even parity bit, stop bit (0). Completed good words
// are handed to a one-deep valid/ready buffer.
// Build option: define SERIAL_DESER_PARITY_EN to add the parity bit and
// make parity_err live; otherwise parity_err is constant 0.
//   clk, rst    : clock, asynchronous active-low reset
//   din, bit_en : serial line and its sample strobe
//   data_out, data_valid, data_ready : output word handshake
//   busy        : receiver is inside a frame
//   frame_err, parity_err, overrun   : one-cycle status pulses
module serial_deser
  import serial_deser_pkg::*;
  #(parameter int WIDTH = 8)
  (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             bit_en,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun
  );

  localparam int CNT_W = $clog2(WIDTH + 1);

  sd_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             frame_err_q, frame_err_d;
  logic             frame_good;
`ifdef SERIAL_DESER_PARITY_EN
  logic             par_q, par_d;
  logic             parity_err_q, parity_err_d;
  logic             parity_bad;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    frame_good  = 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
    parity_bad   = 1'b0;
`endif
    case (state_q)
      SD_IDLE: begin
        if (bit_en && sd_is_start(din)) begin
          state_d = SD_DATA;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      SD_DATA: begin
        if (bit_en) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q == CNT_W'(i)) begin
              shift_d[i] = din;
            end
          end
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            cnt_d = '0;
`ifdef SERIAL_DESER_PARITY_EN
            state_d = SD_PAR;
`else
            state_d = SD_STOP;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      SD_PAR: begin
`ifdef SERIAL_DESER_PARITY_EN
        if (bit_en) begin
          par_d   = din;
          state_d = SD_STOP;
        end
`else
        state_d = SD_IDLE;
`endif
      end
      SD_STOP: begin
        if (bit_en) begin
          state_d     = SD_IDLE;
          frame_err_d = (din != SD_STOP_LEVEL);
`ifdef SERIAL_DESER_PARITY_EN
          // Even parity: payload plus parity bit must XOR to zero.
          parity_bad   = ^{shift_q, par_q};
          parity_err_d = parity_bad;
          frame_good   = !frame_err_d && !parity_bad;
`else
          frame_good   = !frame_err_d;
`endif
        end
      end
      default: state_d = SD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SD_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
`ifdef SERIAL_DESER_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  serial_deser_obuf #(.WIDTH(WIDTH)) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .load      (frame_good),
    .load_data (shift_q),
    .ready     (data_ready),
    .data_out  (data_out),
    .valid     (data_valid),
    .overrun   (overrun)
  );

  assign busy      = (state_q != SD_IDLE);
  assign frame_err = frame_err_q;
`ifdef SERIAL_DESER_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deser.sv
// tb_serial_deser
// Scenario tasks plus a randomized frame run checked against a
// transaction-level model of the one-deep output buffer.
module tb_serial_deser;

  localparam int W = 8;
`ifdef SERIAL_DESER_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         din = 1'b0;
  logic         bit_en = 1'b0;
  logic         data_ready = 1'b0;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         busy;
  logic         frame_err;
  logic         parity_err;
  logic         overrun;

  int   errors = 0;
  int   checks = 0;
  logic pre_valid;

  serial_deser #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .bit_en     (bit_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stall(input int gap);
    for (int g = 0; g < gap; g++) begin
      bit_en = 1'b0;
      din    = 1'($urandom);
      tick();
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    stall(gap);
    din    = b;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    din    = 1'b0;
  endtask

  // Sends one whole frame; returns just after the stop-sample edge.
  task automatic send_frame(input logic [W-1:0] p, input logic par_flip,
                            input logic stop_bit, input logic rdy_stop,
                            input int gap);
    send_bit(1'b1, gap);
    for (int i = 0; i < W; i++) send_bit(p[i], gap);
    if (HAS_PAR) send_bit((^p) ^ par_flip, gap);
    stall(gap);
    pre_valid  = data_valid;
    din        = stop_bit;
    bit_en     = 1'b1;
    data_ready = rdy_stop;
    tick();
    bit_en     = 1'b0;
    din        = 1'b0;
    data_ready = 1'b0;
    $display("frame payload=%h par_flip=%b stop=%b rdy=%b gap=%0d -> valid=%b out=%h ferr=%b perr=%b ovr=%b",
             p, par_flip, stop_bit, rdy_stop, gap, data_valid, data_out,
             frame_err, parity_err, overrun);
  endtask

  task automatic drain();
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #2;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", data_valid); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data: got %h want 00", data_out); end
    checks++; if ({busy, frame_err, parity_err, overrun} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {busy, frame_err, parity_err, overrun}); end
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_clean();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 0);
    checks++; if (pre_valid !== 1'b0) begin errors++; $display("FAIL clean_early_valid: got %b want 0", pre_valid); end
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL clean_valid: got %b want 1", data_valid); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL clean_data: got %h want a5", data_out); end
    checks++; if ({frame_err, parity_err, overrun, busy} !== 4'b0) begin errors++; $display("FAIL clean_flags: got %b want 0000", {frame_err, parity_err, overrun, busy}); end
    drain();
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL clean_accept: got %b want 0", data_valid); end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0);
    checks++; if (data_out !== 8'h3C) begin errors++; $display("FAIL b2b_first: got %h want 3c", data_out); end
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 0);
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", data_valid); end
    checks++; if (data_out !== 8'hC3) begin errors++; $display("FAIL b2b_data: got %h want c3", data_out); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    drain();
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 0);
    checks++; if (data_out !== 8'h11) begin errors++; $display("FAIL ovr_data: got %h want 11", data_out); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse: got %b want 1", overrun); end
    tick();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_width: got %b want 0", overrun); end
    checks++; if (data_valid !== 1'b1 || data_out !== 8'h11) begin errors++; $display("FAIL ovr_hold: got %b/%h want 1/11", data_valid, data_out); end
    drain();
  endtask

  task automatic test_frame_err();
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 0);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_pulse: got %b want 1", frame_err); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid: got %b want 0", data_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy: got %b want 0", busy); end
    tick();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_width: got %b want 0", frame_err); end
  endtask

`ifdef SERIAL_DESER_PARITY_EN
  task automatic test_parity();
    send_frame(8'h07, 1'b0, 1'b0, 1'b0, 0);
    checks++; if (data_valid !== 1'b1 || data_out !== 8'h07) begin errors++; $display("FAIL par_good: got %b/%h want 1/07", data_valid, data_out); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_good_err: got %b want 0", parity_err); end
    drain();
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 0);
    checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL par_bad_err: got %b want 1", parity_err); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL par_bad_valid: got %b want 0", data_valid); end
    tick();
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_width: got %b want 0", parity_err); end
  endtask
`endif

  task automatic test_reset_mid();
    send_frame(8'h99, 1'b0, 1'b0, 1'b0, 0);
    send_bit(1'b1, 0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
    rst = 1'b0;
    #1;
    checks++; if ({data_valid, busy, frame_err, parity_err, overrun} !== 5'b0) begin errors++; $display("FAIL mid_reset_flags: got %b want 00000", {data_valid, busy, frame_err, parity_err, overrun}); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL mid_reset_data: got %h want 00", data_out); end
    tick();
    rst = 1'b1;
    tick();
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 2);
    checks++; if (data_valid !== 1'b1 || data_out !== 8'h81) begin errors++; $display("FAIL strobe_data: got %b/%h want 1/81", data_valid, data_out); end
    drain();
  endtask

  task automatic test_random();
    logic         m_valid;
    logic [W-1:0] m_word;
    m_valid = 1'b0;
    m_word  = '0;
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] p;
      logic         fbad, pflip, rdy, good, exp_ovr;
      int           gap;
      p     = W'($urandom);
      fbad  = ($urandom_range(0, 3) == 0);
      pflip = HAS_PAR && ($urandom_range(0, 3) == 0);
      rdy   = ($urandom_range(0, 3) == 0);
      gap   = $urandom_range(0, 2);
      send_frame(p, pflip, fbad, rdy, gap);
      good    = !fbad && !pflip;
      exp_ovr = good && m_valid && !rdy;
      if (good && (!m_valid || rdy)) begin
        m_word  = p;
        m_valid = 1'b1;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
      checks++; if (frame_err !== fbad) begin errors++; $display("FAIL rnd_ferr[%0d]: got %b want %b", n, frame_err, fbad); end
      checks++; if (parity_err !== pflip) begin errors++; $display("FAIL rnd_perr[%0d]: got %b want %b", n, parity_err, pflip); end
      checks++; if (overrun !== exp_ovr) begin errors++; $display("FAIL rnd_ovr[%0d]: got %b want %b", n, overrun, exp_ovr); end
      checks++; if (data_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, data_valid, m_valid); end
      if (m_valid) begin
        checks++; if (data_out !== m_word) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", n, data_out, m_word); end
      end
      if ($urandom_range(0, 1) == 1) begin
        drain();
        m_valid = 1'b0;
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_clean();
    test_back_to_back();
    test_overrun();
    test_frame_err();
`ifdef SERIAL_DESER_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
